reqs_buf_ctrl: RTL
==================

# reqs_buf_ctrl

Parametrised ongoing-request buffer controller for the L2 cache. It generalises the fixed single-record request buffer into N_REQS tracked entries, each with tag, set, unstable state and a signed invalidation-ack counter. It allocates entries, detects set conflicts for incoming CPU requests and forwards, and reports when each transaction's acks and data are complete. It sits between the L2 input arbiter and the L2 response/forward handlers.

## Interface
- N_REQS, 4, number of entries (power of two, 2..16)
- TAG_BITS, 20, tag width
- SET_BITS, 8, set width
- STATE_BITS, 3, unstable-state width
- INVACK_BITS, 5, signed ack-counter width (two's complement)
- IDX_BITS, $clog2(N_REQS), entry index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid  in  1  allocation request
- alloc_ready  out  1  at least one free entry
- alloc_tag / alloc_set / alloc_state  in  TAG_BITS / SET_BITS / STATE_BITS  new entry fields
- alloc_idx  out  IDX_BITS  index granted (lowest free)
- lookup_set  in  SET_BITS  set probed for conflict
- lookup_hit  out  1  a valid entry holds lookup_set
- lookup_idx  out  IDX_BITS  lowest hitting index (0 if no hit)
- lookup_tag / lookup_state  out  TAG_BITS / STATE_BITS  fields of lookup_idx
- upd_valid, upd_idx, upd_state  in  1, IDX_BITS, STATE_BITS  overwrite state
- cnt_valid, cnt_idx, cnt_value  in  1, IDX_BITS, INVACK_BITS  data response arrived; add expected ack count
- ack_valid, ack_idx  in  1, IDX_BITS  one inv-ack arrived; decrement
- free_valid, free_idx  in  1, IDX_BITS  release entry
- complete_valid, complete_idx  out  1, IDX_BITS  entry has data and counter == 0
- empty, full  out  1 each
- occupancy  out  IDX_BITS+1  valid-entry count

## Operation
- Per entry: valid, tag, set, state, cnt (signed), data_rcvd, done_sent.
- Allocate when alloc_valid && alloc_ready: entry alloc_idx gets valid=1, fields loaded, cnt=0, data_rcvd=0, done_sent=0. alloc_valid with alloc_ready=0 is ignored.
- alloc_ready, alloc_idx, lookup_*, empty, full, occupancy are combinational from registered entry state only.
- upd: state[upd_idx] <= upd_state if entry valid; else ignored.
- cnt: cnt += cnt_value, data_rcvd <= 1. ack: cnt -= 1. Counter may go negative (acks before data). Same cycle, same index: cnt += cnt_value - 1. Arithmetic modulo 2^INVACK_BITS, no saturation.
- Completion: when an entry is valid, data_rcvd=1, cnt==0, done_sent=0, raise complete for that index and set done_sent. Multiple eligible entries: lowest index first, others on following cycles.
- free: clears valid and all fields. Free wins over upd/cnt/ack to the same index in the same cycle. Free of an invalid entry: no effect.
- Operations on invalid indices (upd/cnt/ack): ignored.

## Timing
- Reset: all entries invalid; alloc_ready=1, alloc_idx=0, lookup_hit=0, lookup_idx=0, lookup_tag=0, lookup_state=0, complete_valid=0, complete_idx=0, empty=1, full=0, occupancy=0.
- Allocation visible to lookup and occupancy the cycle after the handshake.
- Entry freed in cycle t is allocatable from t+1 (alloc_ready not bypassed); alloc and free in the same cycle both take effect.
- complete_valid registered: asserted the cycle after the update that makes the entry eligible; one-cycle pulse per transaction.
- Reset asserted mid-transaction clears everything asynchronously; no completion is emitted for lost entries.

## Configuration
- REQS_BUF_STATS_EN defined: adds outputs peak_occ (IDX_BITS+1, max occupancy since reset) and alloc_stall_cnt (16 bits, cycles with alloc_valid && !alloc_ready, saturating at 0xFFFF); both reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then 4 allocs (N_REQS=4) set 0x10..0x13 -> alloc_idx 0,1,2,3; full=1, occupancy=4, fifth alloc ignored.
- Alloc set 0x2A, tag 0x12345; next cycle lookup_set=0x2A -> lookup_hit=1, lookup_idx=0, lookup_tag=0x12345; lookup 0x2B -> hit=0.
- Entry 1: two acks, then cnt_value=2 -> cnt -1, -2, 0; complete_valid=1 with complete_idx=1 one cycle after cnt, single pulse.
- cnt_value=1 and ack same cycle on entry 2 -> cnt=0, complete next cycle.
- Full buffer, free idx 2 and alloc same cycle -> alloc ignored; next cycle alloc gets idx 2.
- Entries 0 and 3 eligible same cycle -> complete_idx 0 then 3 on consecutive cycles; async reset mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reqs_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : reqs_buf_ctrl_if
// Purpose  : Bundles the allocation, lookup, update, counter, ack, free and
//            completion signals of the L2 ongoing-request buffer controller.
// Ports    : none (interface); modport slave = controller side,
//            modport master = arbiter / response-handler side.
// Options  : REQS_BUF_STATS_EN adds peak_occ and alloc_stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
interface reqs_buf_ctrl_if #(
    parameter int N_REQS      = 4,
    parameter int TAG_BITS    = 20,
    parameter int SET_BITS    = 8,
    parameter int STATE_BITS  = 3,
    parameter int INVACK_BITS = 5,
    parameter int IDX_BITS    = $clog2(N_REQS)
);
    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [TAG_BITS-1:0]    alloc_tag;
    logic [SET_BITS-1:0]    alloc_set;
    logic [STATE_BITS-1:0]  alloc_state;
    logic [IDX_BITS-1:0]    alloc_idx;

    logic [SET_BITS-1:0]    lookup_set;
    logic                   lookup_hit;
    logic [IDX_BITS-1:0]    lookup_idx;
    logic [TAG_BITS-1:0]    lookup_tag;
    logic [STATE_BITS-1:0]  lookup_state;

    logic                   upd_valid;
    logic [IDX_BITS-1:0]    upd_idx;
    logic [STATE_BITS-1:0]  upd_state;

    logic                   cnt_valid;
    logic [IDX_BITS-1:0]    cnt_idx;
    logic [INVACK_BITS-1:0] cnt_value;

    logic                   ack_valid;
    logic [IDX_BITS-1:0]    ack_idx;

    logic                   free_valid;
    logic [IDX_BITS-1:0]    free_idx;

    logic                   complete_valid;
    logic [IDX_BITS-1:0]    complete_idx;

    logic                   empty;
    logic                   full;
    logic [IDX_BITS:0]      occupancy;
`ifdef REQS_BUF_STATS_EN
    logic [IDX_BITS:0]      peak_occ;
    logic [15:0]            alloc_stall_cnt;
`endif

    modport slave (
        input  alloc_valid, alloc_tag, alloc_set, alloc_state,
        output alloc_ready, alloc_idx,
        input  lookup_set,
        output lookup_hit, lookup_idx, lookup_tag, lookup_state,
        input  upd_valid, upd_idx, upd_state,
        input  cnt_valid, cnt_idx, cnt_value,
        input  ack_valid, ack_idx,
        input  free_valid, free_idx,
        output complete_valid, complete_idx,
        output empty, full, occupancy
`ifdef REQS_BUF_STATS_EN
        , output peak_occ, alloc_stall_cnt
`endif
    );

    modport master (
        output alloc_valid, alloc_tag, alloc_set, alloc_state,
        input  alloc_ready, alloc_idx,
        output lookup_set,
        input  lookup_hit, lookup_idx, lookup_tag, lookup_state,
        output upd_valid, upd_idx, upd_state,
        output cnt_valid, cnt_idx, cnt_value,
        output ack_valid, ack_idx,
        output free_valid, free_idx,
        input  complete_valid, complete_idx,
        input  empty, full, occupancy
`ifdef REQS_BUF_STATS_EN
        , input peak_occ, alloc_stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/reqs_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reqs_buf_ctrl
// Purpose  : N_REQS-entry ongoing-request buffer for the L2 cache. Tracks tag,
//            set, unstable state and a two's-complement inv-ack counter per
//            entry; allocates the lowest free entry, reports set conflicts
//            and pulses completion once data has arrived and acks balance.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - reqs_buf_ctrl_if.slave (alloc / lookup / upd / cnt /
//                   ack / free / complete / status)
// Options  : REQS_BUF_STATS_EN adds peak_occ and alloc_stall_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module reqs_buf_ctrl #(
    parameter int N_REQS      = 4,
    parameter int TAG_BITS    = 20,
    parameter int SET_BITS    = 8,
    parameter int STATE_BITS  = 3,
    parameter int INVACK_BITS = 5,
    parameter int IDX_BITS    = $clog2(N_REQS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    reqs_buf_ctrl_if.slave     bus
);
    // Per-entry registered state and next-state
    logic                   valid_q [N_REQS];
    logic                   valid_d [N_REQS];
    logic [TAG_BITS-1:0]    tag_q   [N_REQS];
    logic [TAG_BITS-1:0]    tag_d   [N_REQS];
    logic [SET_BITS-1:0]    set_q   [N_REQS];
    logic [SET_BITS-1:0]    set_d   [N_REQS];
    logic [STATE_BITS-1:0]  state_q [N_REQS];
    logic [STATE_BITS-1:0]  state_d [N_REQS];
    logic [INVACK_BITS-1:0] cnt_q   [N_REQS];   // two's complement
    logic [INVACK_BITS-1:0] cnt_d   [N_REQS];
    logic                   data_q  [N_REQS];
    logic                   data_d  [N_REQS];
    logic                   done_q  [N_REQS];
    logic                   done_d  [N_REQS];

    logic                   comp_valid_q, comp_valid_d;
    logic [IDX_BITS-1:0]    comp_idx_q,   comp_idx_d;

    logic [IDX_BITS:0]      w_count;
    logic                   w_any_free;
    logic [IDX_BITS-1:0]    w_alloc_idx;
    logic                   w_hit;
    logic [IDX_BITS-1:0]    w_hit_idx;
    logic                   w_elig;
    logic [IDX_BITS-1:0]    w_elig_idx;
    logic                   w_alloc_fire;
    logic [IDX_BITS-1:0]    w_sel;

    // Status, lookup and completion pick. Scanning from the top down lets the
    // lowest matching index win.
    always_comb begin
        w_count     = '0;
        w_any_free  = 1'b0;
        w_alloc_idx = '0;
        w_hit       = 1'b0;
        w_hit_idx   = '0;
        w_elig      = 1'b0;
        w_elig_idx  = '0;
        for (int i = N_REQS - 1; i >= 0; i--) begin
            if (valid_q[i]) begin
                w_count = w_count + (IDX_BITS+1)'(1);
            end else begin
                w_any_free  = 1'b1;
                w_alloc_idx = IDX_BITS'(i);
            end
            if (valid_q[i] && set_q[i] == bus.lookup_set) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_BITS'(i);
            end
            // An entry being freed this cycle must not report completion.
            if (valid_q[i] && data_q[i] && cnt_q[i] == '0 && !done_q[i] &&
                !(bus.free_valid && bus.free_idx == IDX_BITS'(i))) begin
                w_elig     = 1'b1;
                w_elig_idx = IDX_BITS'(i);
            end
        end
    end

    assign w_alloc_fire = bus.alloc_valid && w_any_free;

    // Entry next-state. Free dominates every other operation on a valid
    // entry; only an invalid entry can be (re)allocated, so alloc never
    // collides with free/upd/cnt/ack on a live entry.
    always_comb begin
        w_sel        = '0;
        comp_valid_d = w_elig;
        comp_idx_d   = w_elig_idx;
        for (int i = 0; i < N_REQS; i++) begin
            w_sel      = IDX_BITS'(i);
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            set_d[i]   = set_q[i];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            data_d[i]  = data_q[i];
            done_d[i]  = done_q[i];
            if (valid_q[i]) begin
                if (bus.free_valid && bus.free_idx == w_sel) begin
                    valid_d[i] = 1'b0;
                    tag_d[i]   = '0;
                    set_d[i]   = '0;
                    state_d[i] = '0;
                    cnt_d[i]   = '0;
                    data_d[i]  = 1'b0;
                    done_d[i]  = 1'b0;
                end else begin
                    if (bus.upd_valid && bus.upd_idx == w_sel)
                        state_d[i] = bus.upd_state;
                    // Wraps modulo 2^INVACK_BITS; acks may arrive before data.
                    cnt_d[i] = cnt_q[i]
                             + ((bus.cnt_valid && bus.cnt_idx == w_sel) ? bus.cnt_value : '0)
                             - ((bus.ack_valid && bus.ack_idx == w_sel) ? INVACK_BITS'(1) : '0);
                    if (bus.cnt_valid && bus.cnt_idx == w_sel)
                        data_d[i] = 1'b1;
                    if (w_elig && w_elig_idx == w_sel)
                        done_d[i] = 1'b1;
                end
            end else if (w_alloc_fire && w_alloc_idx == w_sel) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = bus.alloc_tag;
                set_d[i]   = bus.alloc_set;
                state_d[i] = bus.alloc_state;
                cnt_d[i]   = '0;
                data_d[i]  = 1'b0;
                done_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQS; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                set_q[i]   <= '0;
                state_q[i] <= '0;
                cnt_q[i]   <= '0;
                data_q[i]  <= 1'b0;
                done_q[i]  <= 1'b0;
            end
            comp_valid_q <= 1'b0;
            comp_idx_q   <= '0;
        end else begin
            for (int i = 0; i < N_REQS; i++) begin
                valid_q[i] <= valid_d[i];
                tag_q[i]   <= tag_d[i];
                set_q[i]   <= set_d[i];
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                data_q[i]  <= data_d[i];
                done_q[i]  <= done_d[i];
            end
            comp_valid_q <= comp_valid_d;
            comp_idx_q   <= comp_idx_d;
        end
    end

    assign bus.alloc_ready    = w_any_free;
    assign bus.alloc_idx      = w_alloc_idx;
    assign bus.lookup_hit     = w_hit;
    assign bus.lookup_idx     = w_hit_idx;
    assign bus.lookup_tag     = tag_q[w_hit_idx];
    assign bus.lookup_state   = state_q[w_hit_idx];
    assign bus.complete_valid = comp_valid_q;
    assign bus.complete_idx   = comp_idx_q;
    assign bus.empty          = (w_count == '0);
    assign bus.full           = (w_count == (IDX_BITS+1)'(N_REQS));
    assign bus.occupancy      = w_count;

`ifdef REQS_BUF_STATS_EN
    logic [IDX_BITS:0] peak_occ_q, peak_occ_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    always_comb begin
        peak_occ_d  = (w_count > peak_occ_q) ? w_count : peak_occ_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.alloc_valid && !w_any_free && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_occ_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            peak_occ_q  <= peak_occ_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.peak_occ        = peak_occ_q;
    assign bus.alloc_stall_cnt = stall_cnt_q;
`else
    // Statistics outputs and counters are not built.
`endif
endmodule
`default_nettype wire
